rf_write_arbiter: RTL and testbench



---
 rtl/rf_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/rf_write_arbiter.sv | 76 +++++++
 tb/tb_rf_write_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants, write-request record and round-robin pick helper for the
// register-file write-port arbiter.
package rf_pkg;

  localparam int XLEN    = 32;
  localparam int AW      = 5;
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } rf_wr_req_t;

  // First set bit of valid_mask at or above ptr, wrapping modulo n (n <= MAX_REQ).
  // Returns ptr when nothing is set; callers qualify with |valid_mask.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid_mask,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [3:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(n)) idx = idx - 4'(n);
      if (!found && k < n && valid_mask[idx[2:0]]) begin
        rr_pick = idx[2:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: N-wide request vector in, one-hot grant plus index out.
// Every grant is assumed accepted, so the pointer moves whenever any request is set.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  import rf_pkg::*;

  localparam int IW = $clog2(N);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    win = IW'(rr_pick(MAX_REQ'(req), 3'(rr_ptr), N));
    gnt = '0;
    if (|req) gnt[win] = 1'b1;
  end

  assign gnt_idx = win;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (|req) begin
      rr_ptr <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port among NUM_REQ requesters, latency 1.
// Define RF_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module rf_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = rf_pkg::XLEN,
  parameter int AW      = rf_pkg::AW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*XLEN-1:0]    req_data,
  input  logic                       stall,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [2**AW-1:0]           pend_mask
);
  import rf_pkg::*;

  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] eligible;
  logic [GW-1:0]      win;
  logic               handshake;
  logic [AW-1:0]      sel_addr;
  logic [XLEN-1:0]    sel_data;

  // Ready is forced low while reset is held, not just after the first edge.
  assign eligible = req_valid & {NUM_REQ{~stall & rst_n}};

`ifdef RF_ARB_FIXED_PRIO_EN
  always_comb begin
    win       = GW'(rr_pick(MAX_REQ'(eligible), 3'd0, NUM_REQ));
    req_ready = '0;
    if (|eligible) req_ready[win] = 1'b1;
  end
`else
  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (eligible),
    .gnt     (req_ready),
    .gnt_idx (win)
  );
`endif

  assign handshake = |(req_valid & req_ready);
  assign sel_addr  = req_addr[int'(win)*AW +: AW];
  assign sel_data  = req_data[int'(win)*XLEN +: XLEN];

  // Writes to x0 still take a grant slot but never raise rf_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= '0;
    end else if (handshake) begin
      rf_we    <= (sel_addr != '0);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
      grant_id <= win;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    if (rf_we) pend_mask[rf_waddr] = 1'b1;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed, table-driven bench for rf_write_arbiter (NUM_REQ=3, XLEN=32, AW=5).
module tb_rf_write_arbiter;
  import rf_pkg::*;

`ifdef RF_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  grant_id;
  logic [31:0] pend_mask;

  int total = 0;
  int bad   = 0;

  rf_write_arbiter #(.NUM_REQ(3), .XLEN(32), .AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .stall     (stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .grant_id  (grant_id),
    .pend_mask (pend_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  valid;
    logic        stall;
    rf_wr_req_t  rq [3];
    logic [2:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_pend(input logic we, input logic [4:0] a);
    return we ? (32'h1 << a) : 32'h0;
  endfunction

  // Requester i writes register i+1 with data (i+1)*0x100 unless a row overrides it.
  function automatic vec_t mk(input logic [2:0] v, input logic s, input logic [2:0] er,
                              input logic ewe, input logic [4:0] ewa,
                              input logic [31:0] ewd, input logic [1:0] eg);
    vec_t r;
    r.valid = v;
    r.stall = s;
    for (int i = 0; i < 3; i++) begin
      r.rq[i].addr = 5'(i + 1);
      r.rq[i].data = 32'((i + 1) * 32'h100);
    end
    r.e_ready = er;
    r.e_we    = ewe;
    r.e_waddr = ewa;
    r.e_wdata = ewd;
    r.e_gid   = eg;
    return r;
  endfunction

  function automatic vec_t fair_row(input int g);
    return mk(3'b111, 1'b0, 3'(1 << g), 1'b1, 5'(g + 1), 32'((g + 1) * 32'h100), 2'(g));
  endfunction

  task automatic drive(input vec_t v);
    req_valid = v.valid;
    stall     = v.stall;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*5 +: 5]   = v.rq[i].addr;
      req_data[i*32 +: 32] = v.rq[i].data;
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1;
    check({tag, ".ready"}, 32'(req_ready), 32'(v.e_ready));
    @(posedge clk);
    #1;
    check({tag, ".we"},    32'(rf_we),    32'(v.e_we));
    check({tag, ".waddr"}, 32'(rf_waddr), 32'(v.e_waddr));
    check({tag, ".wdata"}, rf_wdata,      v.e_wdata);
    check({tag, ".gid"},   32'(grant_id), 32'(v.e_gid));
    check({tag, ".pend"},  pend_mask,     exp_pend(v.e_we, v.e_waddr));
  endtask

  initial begin
    vec_t r;
    vec_t stall_row;

    // Single write from requester 1
    r = mk(3'b010, 1'b0, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
    r.rq[1] = '{addr: 5'd5, data: 32'hDEADBEEF};
    tbl.push_back(r);
    // x0 write from requester 2: accepted, dropped
    r = mk(3'b100, 1'b0, 3'b100, 1'b0, 5'd0, 32'h1234, 2'd2);
    r.rq[2] = '{addr: 5'd0, data: 32'h1234};
    tbl.push_back(r);
    // All valid for six cycles
    for (int k = 0; k < 6; k++) tbl.push_back(fair_row(FIXED ? 0 : k % 3));
    // Same destination in consecutive cycles, issued in grant order
    r = mk(3'b011, 1'b0, 3'b001, 1'b1, 5'd7, 32'hA0A0, 2'd0);
    r.rq[0] = '{addr: 5'd7, data: 32'hA0A0};
    r.rq[1] = '{addr: 5'd7, data: 32'hB0B0};
    tbl.push_back(r);
    r.valid = 3'b010; r.e_ready = 3'b010; r.e_wdata = 32'hB0B0; r.e_gid = 2'd1;
    tbl.push_back(r);
    // Idle: rf_we drops, address/data/id hold
    tbl.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0, 5'd7, 32'hB0B0, 2'd1));
    // Leave the pointer at 1 before the stall
    tbl.push_back(fair_row(FIXED ? 0 : 2));
    tbl.push_back(fair_row(0));

    rst_n = 1'b0;
    drive(mk(3'b111, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 2'd0));
    #12;
    check("rst.ready", 32'(req_ready), 32'h0);
    check("rst.we",    32'(rf_we),     32'h0);
    check("rst.pend",  pend_mask,      32'h0);
    #1 rst_n = 1'b1;
    #1;
    check("rst.first_grant", 32'(req_ready), 32'h1);
    req_valid = 3'b000;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Stall: the write registered last cycle is still visible, no new grant
    stall_row = mk(3'b111, 1'b1, 3'b000, 1'b0, 5'd1, 32'h100, 2'd0);
    drive(stall_row);
    #1;
    check("stall.ready",    32'(req_ready), 32'h0);
    check("stall.inflight", 32'(rf_we),     32'h1);
    @(posedge clk);
    #1;
    check("stall.we",   32'(rf_we),   32'h0);
    check("stall.pend", pend_mask,    32'h0);
    check("stall.gid",  32'(grant_id), 32'h0);
    apply(stall_row, "stall2");
    apply(stall_row, "stall3");
    apply(fair_row(FIXED ? 0 : 1), "resume");

    // Asynchronous reset between clock edges while a write is registered
    #2 rst_n = 1'b0;
    #1;
    check("areset.we",    32'(rf_we),     32'h0);
    check("areset.pend",  pend_mask,      32'h0);
    check("areset.waddr", 32'(rf_waddr),  32'h0);
    check("areset.wdata", rf_wdata,       32'h0);
    check("areset.gid",   32'(grant_id),  32'h0);
    check("areset.ready", 32'(req_ready), 32'h0);
    #1 rst_n = 1'b1;
    #1;
    check("areset.ptr", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    check("areset.post_gid",  32'(grant_id), 32'h0);
    check("areset.post_we",   32'(rf_we),    32'h1);
    check("areset.post_pend", pend_mask,     32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
